inv_shift_rows_stream: RTL and testbench
========================================

Name: inv_shift_rows_stream

Overview:
- Byte-serial AES InvShiftRows stage for the AES-256 decryption datapath.
- Accepts a 128-bit state as 16 bytes over a valid/ready stream and buffers each full state.
- Re-emits the state as 16 bytes in InvShiftRows order.
- Ping-pong buffering sustains 1 byte/cycle with no bubbles between back-to-back blocks.

Parameters:
- DATA_W, 8, byte width. Fixed; other values unsupported.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-high reset.
- s_valid  in  1  input byte valid.
- s_ready  out  1  input can accept a byte.
- s_data  in  8  input state byte.
- s_last  in  1  marks input byte 15 of a block.
- m_valid  out  1  output byte valid.
- m_ready  in  1  downstream accepts the output byte.
- m_data  out  8  output state byte.
- m_last  out  1  marks output byte 15 of a block.
- err  out  1  one-cycle framing-error pulse.

Behaviour:
- Byte order: stream byte k (0..15) is state byte k, where k = 4c + r (row r, column c, column-major). This matches the 128-bit state vector, byte k = bits [8k +: 8].
- InvShiftRows: out(r,c) = in(r,(c-r) mod 4).
- Output byte j is taken from input byte P[j], with P = 0,13,10,7,4,1,14,11,8,5,2,15,12,9,6,3.
- Storage: two 16x8 banks (bank0, bank1) and per-bank full flags.
  - Write side: bank pointer wb, counter wcnt[3:0].
  - Read side: bank pointer rb, counter rcnt[3:0].
- Input handshake: a byte transfers when s_valid && s_ready.
  - s_ready = !full[wb].
  - Each accepted byte is written to bank[wb][wcnt], then wcnt increments.
- Block close on the 16th byte (wcnt==15 accepted):
  - full[wb] <= 1, wb toggles, wcnt <= 0.
  - If s_last is low on that byte, err pulses; the block is still closed and kept.
- Early s_last (accepted with wcnt<15):
  - err pulses and the partial block is discarded (wcnt <= 0).
  - full and wb are unchanged.
- Output: m_valid = full[rb]; m_data = bank[rb][P[rcnt]]; m_last = m_valid && rcnt==15. All three are combinational from registers.
- Output handshake: a byte transfers when m_valid && m_ready, then rcnt increments.
  - On rcnt==15 transfer: full[rb] <= 0, rb toggles, rcnt <= 0.
- Latency: the first output byte is valid in the cycle after the 16th input byte is accepted.
- Simultaneous events:
  - Filling one bank while draining the other is legal in the same cycle.
  - A bank freed by its final read can be written from the next cycle onward. s_ready is not combinationally dependent on m_ready.
- Throughput: with m_ready held high, s_ready stays high indefinitely and the output runs at 1 byte/cycle.
- Holding: with m_valid high and m_ready low, m_data and m_last stay stable.
- Reset, asserted at any time including mid-block or mid-drain:
  - Banks, full flags, wb, rb, wcnt and rcnt clear immediately; partial data is lost.
  - Outputs under reset: s_ready=1, m_valid=0, m_data=0x00, m_last=0, err=0.
- err: registered, high for exactly one cycle per error, 0 otherwise.

Test Plan:
- Single block: s_data 0x00..0x0F, s_last on 0x0F, m_ready=1 -> m_data 00 0D 0A 07 04 01 0E 0B 08 05 02 0F 0C 09 06 03; m_last on the final 03; first m_valid in the cycle after the 0x0F handshake; err never set.
- Round trip: feed the forward-ShiftRows of state 0x00112233_44556677_8899AABB_CCDDEEFF, i.e. 00 55 AA FF 44 99 EE 33 88 DD 22 77 CC 11 66 BB -> output 00 11 22 ... FF in order.
- Back-to-back: 4 blocks streamed continuously, m_ready=1 -> s_ready never drops after reset; 64 output bytes with no gaps; m_last every 16th byte.
- Backpressure: m_ready=0 while sending 3 blocks -> s_ready drops after the 32nd byte. Raise m_ready -> block 1 drains, s_ready returns the cycle after block 1's last read, and block 3 outputs correctly.
- Framing error: s_last on the 6th byte -> err pulses once, no output. Next 16 bytes 0x10..0x1F with a correct s_last -> output 10 1D 1A 17 ...
- Reset mid-operation: assert rst after 9 input bytes and during a drain at rcnt=5 -> m_valid=0 and s_ready=1 immediately. A fresh block afterwards is output correctly with no stale bytes.

Source files
------------

// File: rtl/inv_shift_rows_stream.sv
// Byte-serial AES InvShiftRows stage: collects 16-byte states into a ping-pong
// buffer and replays each state in InvShiftRows byte order at 1 byte/cycle.
module inv_shift_rows_stream #(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic [DATA_W-1:0] s_data,
    input  logic              s_last,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [DATA_W-1:0] m_data,
    output logic              m_last,
    output logic              err
);

    logic [DATA_W-1:0] bank_q [2][16];
    logic [DATA_W-1:0] bank_d [2][16];
    logic [1:0]        full_q, full_d;
    logic              wb_q, wb_d;
    logic              rb_q, rb_d;
    logic [3:0]        wcnt_q, wcnt_d;
    logic [3:0]        rcnt_q, rcnt_d;
    logic              err_q, err_d;
    logic              s_fire_s;
    logic              m_fire_s;

    // Output byte j = 4c + r comes from input byte 4*((c - r) mod 4) + r.
    function automatic logic [3:0] src_index(input logic [3:0] j);
        logic [1:0] row;
        logic [1:0] col;
        row = j[1:0];
        col = j[3:2] - j[1:0];
        return {col, row};
    endfunction

    assign s_ready  = !full_q[wb_q];
    assign m_valid  = full_q[rb_q];
    assign m_data   = bank_q[rb_q][src_index(rcnt_q)];
    assign m_last   = full_q[rb_q] && (rcnt_q == 4'd15);
    assign err      = err_q;
    assign s_fire_s = s_valid && !full_q[wb_q];
    assign m_fire_s = full_q[rb_q] && m_ready;

    // Next-state for both buffer sides; a write and a read always target
    // different banks because one needs full clear and the other full set.
    always_comb begin
        bank_d = bank_q;
        full_d = full_q;
        wb_d   = wb_q;
        rb_d   = rb_q;
        wcnt_d = wcnt_q;
        rcnt_d = rcnt_q;
        err_d  = 1'b0;

        if (s_fire_s) begin
            bank_d[wb_q][wcnt_q] = s_data;
            if (wcnt_q == 4'd15) begin
                full_d[wb_q] = 1'b1;
                wb_d         = !wb_q;
                wcnt_d       = 4'd0;
                err_d        = !s_last;
            end else if (s_last) begin
                wcnt_d = 4'd0;
                err_d  = 1'b1;
            end else begin
                wcnt_d = wcnt_q + 4'd1;
            end
        end else begin
            wcnt_d = wcnt_q;
        end

        if (m_fire_s) begin
            if (rcnt_q == 4'd15) begin
                full_d[rb_q] = 1'b0;
                rb_d         = !rb_q;
                rcnt_d       = 4'd0;
            end else begin
                rcnt_d = rcnt_q + 4'd1;
            end
        end else begin
            rcnt_d = rcnt_q;
        end
    end

    // State registers; reset wipes stored data so nothing stale can leak out.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int b = 0; b < 2; b++) begin
                for (int i = 0; i < 16; i++) begin
                    bank_q[b][i] <= '0;
                end
            end
            full_q <= 2'b00;
            wb_q   <= 1'b0;
            rb_q   <= 1'b0;
            wcnt_q <= 4'd0;
            rcnt_q <= 4'd0;
            err_q  <= 1'b0;
        end else begin
            bank_q <= bank_d;
            full_q <= full_d;
            wb_q   <= wb_d;
            rb_q   <= rb_d;
            wcnt_q <= wcnt_d;
            rcnt_q <= rcnt_d;
            err_q  <= err_d;
        end
    end

endmodule

// File: tb/tb_inv_shift_rows_stream.sv
// Scoreboard bench for inv_shift_rows_stream: stimulus pushes expected bytes,
// a negedge monitor pops and compares every output handshake.
module tb_inv_shift_rows_stream;

    logic       clk = 1'b0;
    logic       rst;
    logic       s_valid, s_ready, s_last;
    logic [7:0] s_data;
    logic       m_valid, m_ready, m_last;
    logic [7:0] m_data;
    logic       err;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int err_cnt = 0;
    int stalls  = 0;
    int sent    = 0;
    logic [8:0] exp_q [$];
    int         out_cyc [$];

    // Hand-computed InvShiftRows source index table.
    logic [3:0] p_tab [16] = '{4'd0, 4'd13, 4'd10, 4'd7, 4'd4, 4'd1, 4'd14, 4'd11,
                               4'd8, 4'd5, 4'd2, 4'd15, 4'd12, 4'd9, 4'd6, 4'd3};
    logic [7:0] rt_in [16] = '{8'h00, 8'h55, 8'hAA, 8'hFF, 8'h44, 8'h99, 8'hEE, 8'h33,
                               8'h88, 8'hDD, 8'h22, 8'h77, 8'hCC, 8'h11, 8'h66, 8'hBB};

    inv_shift_rows_stream #(.DATA_W(8)) dut (
        .clk(clk), .rst(rst),
        .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data), .s_last(s_last),
        .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_last(m_last),
        .err(err)
    );

    always #5 clk = !clk;

    always @(posedge clk) cyc++;

    // Monitor: pop and compare on each output handshake.
    always @(negedge clk) begin
        if (err) err_cnt++;
        if (!rst && m_valid && m_ready) begin
            out_cyc.push_back(cyc);
            if (exp_q.size() == 0) begin
                total++; bad++;
                $display("FAIL unexpected_out: got data=%02h last=%0b, required none", m_data, m_last);
            end else begin
                logic [8:0] e;
                e = exp_q.pop_front();
                total++;
                if (m_data !== e[7:0]) begin
                    bad++;
                    $display("FAIL out_data: got %02h required %02h", m_data, e[7:0]);
                end
                total++;
                if (m_last !== e[8]) begin
                    bad++;
                    $display("FAIL out_last: got %0b required %0b (data %02h)", m_last, e[8], e[7:0]);
                end
            end
        end
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] req);
        total++;
        if (got !== req) begin
            bad++;
            $display("FAIL %s: got %0h required %0h", name, got, req);
        end
    endtask

    task automatic send_byte(input logic [7:0] d, input logic l);
        logic ok;
        int   waits;
        s_valid = 1'b1; s_data = d; s_last = l;
        ok = 1'b0; waits = 0;
        do begin
            @(negedge clk);
            ok = s_ready;
            if (!ok) stalls++;
            @(posedge clk);
            #1;
            waits++;
        end while (!ok && waits < 1000);
        if (!ok) begin
            total++; bad++;
            $display("FAIL send_timeout: byte %02h not accepted, required accept", d);
        end
        sent++;
    endtask

    task automatic idle();
        s_valid = 1'b0; s_last = 1'b0; s_data = 8'h00;
    endtask

    task automatic push_block(input logic [7:0] base);
        for (int j = 0; j < 16; j++) exp_q.push_back({(j == 15), base + {4'd0, p_tab[j]}});
    endtask

    task automatic send_seq_block(input logic [7:0] base);
        for (int k = 0; k < 16; k++) send_byte(base + k[7:0], (k == 15));
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 500) begin
            @(posedge clk); #1; n++;
        end
        repeat (2) @(posedge clk);
        #1;
        check("drain_empty", exp_q.size(), 0);
    endtask

    initial begin
        int e0, s0;
        rst = 1'b1; m_ready = 1'b0;
        idle();
        #1;
        check("rst_s_ready", s_ready, 1);
        check("rst_m_valid", m_valid, 0);
        check("rst_m_data", m_data, 8'h00);
        check("rst_m_last", m_last, 0);
        check("rst_err", err, 0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        m_ready = 1'b1;

        // Single block with latency check.
        push_block(8'h00);
        for (int k = 0; k < 15; k++) send_byte(k[7:0], 1'b0);
        check("latency_before", m_valid, 0);
        send_byte(8'h0F, 1'b1);
        check("latency_after", m_valid, 1);
        idle();
        wait_drain();
        check("single_no_err", err_cnt, 0);

        // Round trip of forward-ShiftRows data.
        for (int j = 0; j < 16; j++) exp_q.push_back({(j == 15), j[3:0], j[3:0]});
        for (int k = 0; k < 16; k++) send_byte(rt_in[k], (k == 15));
        idle();
        wait_drain();

        // Back-to-back blocks with no stalls and no output gaps.
        out_cyc.delete();
        s0 = stalls;
        for (int b = 0; b < 4; b++) push_block(8'(b * 16));
        for (int b = 0; b < 4; b++) send_seq_block(8'(b * 16));
        idle();
        wait_drain();
        check("b2b_stalls", stalls - s0, 0);
        check("b2b_count", out_cyc.size(), 64);
        if (out_cyc.size() == 64) check("b2b_gapless", out_cyc[63] - out_cyc[0], 63);

        // Backpressure: three blocks with output stalled.
        m_ready = 1'b0;
        sent = 0;
        out_cyc.delete();
        for (int b = 0; b < 3; b++) push_block(8'h80 + 8'(b * 16));
        fork
            begin
                for (int b = 0; b < 3; b++) begin
                    for (int k = 0; k < 16; k++) begin
                        send_byte(8'h80 + 8'(b * 16 + k), (k == 15));
                        if (b == 1 && k == 15) check("bp_ready_drop", s_ready, 0);
                    end
                end
                idle();
            end
            begin
                int n, rc;
                n = 0;
                while (sent < 32 && n < 200) begin @(posedge clk); #1; n++; end
                repeat (10) @(posedge clk);
                #1;
                check("bp_held", sent, 32);
                m_ready = 1'b1;
                n = 0;
                do begin @(negedge clk); n++; end while (!s_ready && n < 100);
                rc = cyc;
                check("bp_ready_ret_cnt", out_cyc.size() >= 16, 1);
                if (out_cyc.size() >= 16) check("bp_ready_return", rc, out_cyc[15] + 1);
            end
        join
        wait_drain();

        // Framing errors: early s_last drops the block, missing s_last keeps it.
        e0 = err_cnt;
        for (int k = 0; k < 6; k++) send_byte(8'hE0 + k[7:0], (k == 5));
        idle();
        repeat (4) @(posedge clk);
        #1;
        check("early_last_err", err_cnt - e0, 1);
        check("early_last_no_out", m_valid, 0);
        push_block(8'h10);
        send_seq_block(8'h10);
        idle();
        wait_drain();
        check("good_after_err", err_cnt - e0, 1);
        push_block(8'h30);
        for (int k = 0; k < 16; k++) send_byte(8'h30 + k[7:0], 1'b0);
        idle();
        wait_drain();
        check("missing_last_err", err_cnt - e0, 2);

        // Reset mid-fill.
        for (int k = 0; k < 9; k++) send_byte(8'h50 + k[7:0], 1'b0);
        idle();
        rst = 1'b1;
        #1;
        check("rst_fill_m_valid", m_valid, 0);
        check("rst_fill_s_ready", s_ready, 1);
        @(posedge clk); #1 rst = 1'b0;

        // Reset mid-drain at rcnt=5.
        m_ready = 1'b0;
        push_block(8'h60);
        send_seq_block(8'h60);
        idle();
        m_ready = 1'b1;
        repeat (5) @(posedge clk);
        #1 rst = 1'b1;
        #1;
        check("rst_drain_m_valid", m_valid, 0);
        check("rst_drain_s_ready", s_ready, 1);
        check("rst_drain_m_data", m_data, 8'h00);
        check("rst_drain_left", exp_q.size(), 11);
        exp_q.delete();
        @(posedge clk); #1 rst = 1'b0;

        push_block(8'hA0);
        send_seq_block(8'hA0);
        idle();
        wait_drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
